// File: rtl/addsub_accumulator_pkg.sv
// Shared definitions for the add/subtract accumulator: datapath width,
// command encodings and FSM state encodings.
package addsub_accumulator_pkg;

  // Operand and accumulator width; the datapath is built for 4 bits only.
  localparam int WIDTH = 4;

  // Command encodings carried on in_op.
  typedef logic [1:0] op_t;
  localparam op_t OP_LOAD  = 2'b00;
  localparam op_t OP_ADD   = 2'b01;
  localparam op_t OP_SUB   = 2'b10;
  localparam op_t OP_CLEAR = 2'b11;

  // Controller states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage : addsub_accumulator_pkg

// File: rtl/addsub4_core.sv
// Combinational ripple-carry adder/subtractor. Subtraction is performed as
// A + ~B + 1, so the carry-out reads as "no borrow" for subtracts.
module addsub4_core
  import addsub_accumulator_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_subtract,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_c;

  // Ripple the carry from bit 0 upward; the subtract flag doubles as carry-in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_bx   = '0;
    w_s    = '0;
    w_c    = '0;
    w_c[0] = i_subtract;
    for (int i = 0; i < WIDTH; i++) begin
      w_bx[i]  = i_b[i] ^ i_subtract;
      w_s[i]   = i_a[i] ^ w_bx[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & w_bx[i]) | (w_c[i] & (i_a[i] ^ w_bx[i]));
    end
  end

  assign o_sum = {w_c[WIDTH], w_s};

endmodule : addsub4_core

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator: accepts one command in IDLE, executes it against
// the accumulator in EXEC, and holds the registered result in DONE until the
// consumer takes it. All outputs come from registers.
module addsub_accumulator #(
  parameter int WIDTH = 4  // only 4 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  import addsub_accumulator_pkg::*;

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH:0]   r_result;
  logic             r_overflow;
  logic             r_zero;

  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic             w_bx_msb;
  logic             w_ovf;

  assign w_sub = (r_op == OP_SUB);

  addsub4_core u_core (
    .i_a        (r_acc),
    .i_b        (r_operand),
    .i_subtract (w_sub),
    .o_sum      (w_sum)
  );

  // Signed overflow: operands (after subtract inversion) agree in sign but
  // the 4-bit sum's sign differs from A.
  assign w_bx_msb = r_operand[WIDTH-1] ^ w_sub;
  assign w_ovf    = (r_acc[WIDTH-1] == w_bx_msb) & (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

  // Controller and result registers; acc only moves on the EXEC -> DONE edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: every register, including the captured command, is reset so no X ever reaches an output.
      r_state    <= ST_IDLE;
      r_op       <= OP_LOAD;
      r_operand  <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op      <= in_op;
            r_operand <= in_data;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (r_op)
            OP_LOAD: begin
              r_acc      <= r_operand;
              r_result   <= {1'b0, r_operand};
              r_overflow <= 1'b0;
              r_zero     <= (r_operand == '0);
            end
            OP_ADD, OP_SUB: begin
              r_acc      <= w_sum[WIDTH-1:0];
              r_result   <= w_sum;
              r_overflow <= w_ovf;
              r_zero     <= (w_sum[WIDTH-1:0] == '0);
            end
            default: begin  // OP_CLEAR
              r_acc      <= '0;
              r_result   <= '0;
              r_overflow <= 1'b0;
              r_zero     <= 1'b1;
            end
          endcase
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign acc       = r_acc;
  assign carry     = r_result[WIDTH];
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule : addsub_accumulator

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: directed scenarios followed by
// random commands, compared against an arithmetic reference model.
module tb_addsub_accumulator;

  import addsub_accumulator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] result;
  logic [3:0] acc;
  logic       carry;
  logic       overflow;
  logic       zero;

  addsub_accumulator #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .acc       (acc),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (plain integers, computed from the arithmetic rules).
  int         m_acc;
  logic [4:0] m_result;
  logic       m_ovf;
  logic       m_zero;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed4(input int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  task automatic model_apply(input logic [1:0] op, input int b);
    int s;
    case (op)
      OP_LOAD: begin
        m_result = 5'(b);
        m_acc    = b;
        m_ovf    = 1'b0;
      end
      OP_ADD: begin
        m_result = 5'(m_acc + b);
        s        = to_signed4(m_acc) + to_signed4(b);
        m_ovf    = (s > 7) || (s < -8);
        m_acc    = (m_acc + b) % 16;
      end
      OP_SUB: begin
        m_result = 5'(m_acc + 16 - b);
        s        = to_signed4(m_acc) - to_signed4(b);
        m_ovf    = (s > 7) || (s < -8);
        m_acc    = (m_acc - b + 16) % 16;
      end
      default: begin
        m_result = 5'd0;
        m_acc    = 0;
        m_ovf    = 1'b0;
      end
    endcase
    m_zero = (m_acc == 0);
  endtask

  task automatic check_done(input string tag);
    check({tag, ".out_valid"}, 8'(out_valid), 8'd1);
    check({tag, ".in_ready"},  8'(in_ready),  8'd0);
    check({tag, ".result"},    8'(result),    8'(m_result));
    check({tag, ".acc"},       8'(acc),       8'(m_acc));
    check({tag, ".carry"},     8'(carry),     8'(m_result[4]));
    check({tag, ".overflow"},  8'(overflow),  8'(m_ovf));
    check({tag, ".zero"},      8'(zero),      8'(m_zero));
  endtask

  // Issue one command, hold the result for `stall` extra cycles while
  // offering a junk command, then release it and confirm return to IDLE.
  task automatic send(input string tag, input logic [1:0] op, input int b, input int stall);
    @(negedge clk);
    check({tag, ".idle_ready"}, 8'(in_ready), 8'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = 4'(b);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".exec_valid"}, 8'(out_valid), 8'd0);
    check({tag, ".exec_ready"}, 8'(in_ready),  8'd0);
    check({tag, ".exec_acc"},   8'(acc),       8'(m_acc));
    model_apply(op, b);
    @(negedge clk);
    check_done(tag);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_data  = 4'($urandom_range(0, 15));
      @(negedge clk);
      check_done({tag, ".stall"});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".rel_ready"}, 8'(in_ready),  8'd1);
    check({tag, ".rel_valid"}, 8'(out_valid), 8'd0);
    check({tag, ".rel_acc"},   8'(acc),       8'(m_acc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = OP_LOAD;
    in_data   = 4'd0;
    out_ready = 1'b0;
    m_acc     = 0;
    m_result  = 5'd0;
    m_ovf     = 1'b0;
    m_zero    = 1'b1;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst.in_ready",  8'(in_ready),  8'd1);
    check("rst.out_valid", 8'(out_valid), 8'd0);
    check("rst.acc",       8'(acc),       8'd0);
    check("rst.result",    8'(result),    8'd0);
    check("rst.carry",     8'(carry),     8'd0);
    check("rst.overflow",  8'(overflow),  8'd0);
    check("rst.zero",      8'(zero),      8'd1);
    rst = 1'b0;

    // LOAD 5, ADD 3: positive overflow into 8.
    send("load5", OP_LOAD, 5, 0);
    send("add3",  OP_ADD,  3, 0);
    check("add3.const_acc",    8'(acc),      8'd8);
    check("add3.const_result", 8'(result),   8'h08);
    check("add3.const_ovf",    8'(overflow), 8'd1);

    // 8 - 9 borrows to 15; 15 + 1 wraps to 0 with carry.
    send("sub9", OP_SUB, 9, 0);
    check("sub9.const_result", 8'(result), 8'h0F);
    check("sub9.const_carry",  8'(carry),  8'd0);
    send("add1", OP_ADD, 1, 0);
    check("add1.const_result", 8'(result), 8'h10);
    check("add1.const_zero",   8'(zero),   8'd1);

    // 7 - 7 gives zero with no borrow.
    send("load7", OP_LOAD, 7, 0);
    send("sub7",  OP_SUB,  7, 0);
    check("sub7.const_result", 8'(result), 8'h10);

    // CLEAR ignores its operand.
    send("load12", OP_LOAD,  12, 0);
    send("clear",  OP_CLEAR, 7,  0);
    check("clear.const_acc", 8'(acc), 8'd0);

    // Backpressure: result held for 5 cycles with a competing command offered.
    send("load3",    OP_LOAD, 3, 0);
    send("add4_hold", OP_ADD, 4, 5);

    // Reset during EXEC aborts the command.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = OP_LOAD;
    in_data  = 4'd9;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc    = 0;
    m_result = 5'd0;
    m_ovf    = 1'b0;
    m_zero   = 1'b1;
    check("abort.out_valid", 8'(out_valid), 8'd0);
    check("abort.acc",       8'(acc),       8'd0);
    check("abort.zero",      8'(zero),      8'd1);
    check("abort.in_ready",  8'(in_ready),  8'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort.no_valid", 8'(out_valid), 8'd0);
    end

    // Random command stream with random backpressure.
    for (int n = 0; n < 60; n++) begin
      send("rand", 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_addsub_accumulator
